// File: rtl/stack_pkg.sv
// Shared types and defaults for the eForth data-stack controller.
// Holds the primitive opcodes, controller FSM states and operand-count helpers.
package stack_pkg;

    localparam int unsigned DSZ_DEF   = 32;
    localparam int unsigned DEPTH_DEF = 16;

    typedef enum logic [3:0] {
        NOP, LIT, DUP, DROP, SWAP, OVER, ROT, ADD, SUB, AND, OR, XOR, INV
    } op_t;

    typedef enum logic [2:0] {
        IDLE, SW_PUSH, RT_POP, RT_PUSH1, RT_PUSH0
    } state_t;

    // Cells that must sit below TOS for the op to be legal.
    function automatic logic [1:0] min_cells(op_t op);
        if (op == ROT) begin
            return 2'd2;
        end
        if (op inside {DROP, OVER, SWAP, ADD, SUB, AND, OR, XOR}) begin
            return 2'd1;
        end
        return 2'd0;
    endfunction

    function automatic logic grows(op_t op);
        return op inside {LIT, DUP, OVER};
    endfunction

endpackage

// File: rtl/stack_alu.sv
// Combinational ALU for the binary stack primitives and INV.
// Results wrap modulo 2^DSZ; SUB is NOS minus TOS.
module stack_alu
    import stack_pkg::*;
#(
    parameter int unsigned DSZ = DSZ_DEF
) (
    input  op_t            op_i,
    input  logic [DSZ-1:0] nos_i,
    input  logic [DSZ-1:0] tos_i,
    output logic [DSZ-1:0] res_o
);

    always_comb begin
        res_o = tos_i;
        case (op_i)
            ADD:     res_o = nos_i + tos_i;
            SUB:     res_o = nos_i - tos_i;
            AND:     res_o = nos_i & tos_i;
            OR:      res_o = nos_i | tos_i;
            XOR:     res_o = nos_i ^ tos_i;
            INV:     res_o = ~tos_i;
            default: res_o = tos_i;
        endcase
    end

endmodule

// File: rtl/stack_ctl.sv
// Data-stack controller: keeps TOS locally, sequences SWAP/ROT shuffles and
// issues registered push/pop strobes to the attached stack, tracking depth.
module stack_ctl
    import stack_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEF,
    parameter int unsigned DSZ   = DSZ_DEF,
    parameter int unsigned SSZ   = $clog2(DEPTH)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en,
    input  logic           op_valid,
    output logic           op_ready,
    input  op_t            op,
    input  logic [DSZ-1:0] lit,
    output logic [DSZ-1:0] tos,
    output logic [SSZ:0]   depth,
    output logic           err,
    output logic           ss_push,
    output logic           ss_pop,
    output logic [DSZ-1:0] ss_vi,
    input  logic [DSZ-1:0] ss_s0,
    input  logic [DSZ-1:0] ss_s1
);

    localparam logic [SSZ:0] DepthFull = (SSZ+1)'(DEPTH);
    localparam logic [SSZ:0] DepthOne  = (SSZ+1)'(1);

    state_t         state_q, state_d;
    logic [DSZ-1:0] tos_q, tos_d;
    logic [SSZ:0]   depth_q, depth_d;
    logic           err_q, err_d;
    logic [DSZ-1:0] hold0_q, hold0_d;
    logic [DSZ-1:0] hold1_q, hold1_d;
    logic           push_q, push_d;
    logic           pop_q, pop_d;
    logic [DSZ-1:0] vi_q, vi_d;

    logic [DSZ-1:0] alu_res;
    logic [SSZ:0]   need_cells;
    logic           accept;
    logic           violation;

    stack_alu #(
        .DSZ(DSZ)
    ) u_alu (
        .op_i  (op),
        .nos_i (ss_s0),
        .tos_i (tos_q),
        .res_o (alu_res)
    );

    assign op_ready   = (state_q == IDLE) & en;
    assign accept     = op_valid & op_ready;
    assign need_cells = (SSZ+1)'(min_cells(op));
    assign violation  = (depth_q < need_cells) | (grows(op) & (depth_q >= DepthFull));

    // Strobes are held while en is low and presented again once it returns.
    assign ss_push = push_q & en;
    assign ss_pop  = pop_q & en;
    assign ss_vi   = vi_q;
    assign tos     = tos_q;
    assign depth   = depth_q;
    assign err     = err_q;

    always_comb begin
        state_d = state_q;
        tos_d   = tos_q;
        depth_d = depth_q;
        err_d   = err_q;
        hold0_d = hold0_q;
        hold1_d = hold1_q;
        push_d  = push_q;
        pop_d   = pop_q;
        vi_d    = vi_q;

        if (en) begin
            push_d = 1'b0;
            pop_d  = 1'b0;
            vi_d   = '0;
            case (state_q)
                IDLE: begin
                    if (accept && violation) begin
                        err_d = 1'b1;
                    end else if (accept) begin
                        case (op)
                            LIT: begin
                                push_d  = 1'b1;
                                vi_d    = tos_q;
                                tos_d   = lit;
                                depth_d = depth_q + DepthOne;
                            end
                            DUP: begin
                                push_d  = 1'b1;
                                vi_d    = tos_q;
                                depth_d = depth_q + DepthOne;
                            end
                            OVER: begin
                                push_d  = 1'b1;
                                vi_d    = tos_q;
                                tos_d   = ss_s0;
                                depth_d = depth_q + DepthOne;
                            end
                            DROP: begin
                                pop_d   = 1'b1;
                                tos_d   = ss_s0;
                                depth_d = depth_q - DepthOne;
                            end
                            ADD, SUB, AND, OR, XOR: begin
                                pop_d   = 1'b1;
                                tos_d   = alu_res;
                                depth_d = depth_q - DepthOne;
                            end
                            INV: tos_d = alu_res;
                            SWAP: begin
                                hold0_d = tos_q;
                                tos_d   = ss_s0;
                                pop_d   = 1'b1;
                                depth_d = depth_q - DepthOne;
                                state_d = SW_PUSH;
                            end
                            ROT: begin
                                hold0_d = tos_q;
                                hold1_d = ss_s0;
                                tos_d   = ss_s1;
                                pop_d   = 1'b1;
                                depth_d = depth_q - DepthOne;
                                state_d = RT_POP;
                            end
                            default: ;
                        endcase
                    end
                end
                SW_PUSH: begin
                    push_d  = 1'b1;
                    vi_d    = hold0_q;
                    depth_d = depth_q + DepthOne;
                    state_d = IDLE;
                end
                RT_POP: begin
                    pop_d   = 1'b1;
                    depth_d = depth_q - DepthOne;
                    state_d = RT_PUSH1;
                end
                RT_PUSH1: begin
                    push_d  = 1'b1;
                    vi_d    = hold1_q;
                    depth_d = depth_q + DepthOne;
                    state_d = RT_PUSH0;
                end
                RT_PUSH0: begin
                    push_d  = 1'b1;
                    vi_d    = hold0_q;
                    depth_d = depth_q + DepthOne;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            tos_q   <= '0;
            depth_q <= '0;
            err_q   <= 1'b0;
            hold0_q <= '0;
            hold1_q <= '0;
            push_q  <= 1'b0;
            pop_q   <= 1'b0;
            vi_q    <= '0;
        end else begin
            state_q <= state_d;
            tos_q   <= tos_d;
            depth_q <= depth_d;
            err_q   <= err_d;
            hold0_q <= hold0_d;
            hold1_q <= hold1_d;
            push_q  <= push_d;
            pop_q   <= pop_d;
            vi_q    <= vi_d;
        end
    end

endmodule

// File: tb/tb_stack_ctl.sv
// Self-checking bench for stack_ctl: a simple stack memory answers the strobes,
// and a logical data-stack model is compared against the controller every cycle.
module tb_stack_ctl;
    import stack_pkg::*;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b1;
    logic        op_valid = 1'b0;
    op_t         op = NOP;
    logic [31:0] lit = '0;
    logic        op_ready;
    logic [31:0] tos;
    logic [4:0]  depth;
    logic        err;
    logic        ss_push;
    logic        ss_pop;
    logic [31:0] ss_vi;
    logic [31:0] ss_s0;
    logic [31:0] ss_s1;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    stack_ctl #(
        .DEPTH(16),
        .DSZ  (32)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .op_valid(op_valid),
        .op_ready(op_ready),
        .op      (op),
        .lit     (lit),
        .tos     (tos),
        .depth   (depth),
        .err     (err),
        .ss_push (ss_push),
        .ss_pop  (ss_pop),
        .ss_vi   (ss_vi),
        .ss_s0   (ss_s0),
        .ss_s1   (ss_s1)
    );

    // Attached stack memory; its outputs already reflect a strobe in flight.
    logic [31:0] mem [0:63];
    int          sp;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            sp <= 0;
        end else if (ss_push) begin
            mem[6'(sp)] <= ss_vi;
            sp <= sp + 1;
        end else if (ss_pop) begin
            sp <= sp - 1;
        end
    end

    always_comb begin
        ss_s0 = '0;
        ss_s1 = '0;
        if (ss_push) begin
            ss_s0 = ss_vi;
            if (sp >= 1) ss_s1 = mem[6'(sp - 1)];
        end else if (ss_pop) begin
            if (sp >= 2) ss_s0 = mem[6'(sp - 2)];
            if (sp >= 3) ss_s1 = mem[6'(sp - 3)];
        end else begin
            if (sp >= 1) ss_s0 = mem[6'(sp - 1)];
            if (sp >= 2) ss_s1 = mem[6'(sp - 2)];
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Logical model: cells below TOS in a queue (back = NOS), busy cycles left.
    logic [31:0] m_stk [$];
    logic [31:0] m_tos = '0;
    logic        m_err = 1'b0;
    int          busy = 0;

    task automatic model_reset();
        m_stk.delete();
        m_tos = '0;
        m_err = 1'b0;
        busy  = 0;
    endtask

    task automatic model_step();
        logic [31:0] n;
        logic [31:0] a;
        logic [31:0] b;
        int          need;
        bit          grow;
        if (!en) return;
        if (busy > 0) begin
            busy--;
            return;
        end
        if (!op_valid) return;
        need = (op == ROT) ? 2 : ((op inside {DROP, OVER, SWAP, ADD, SUB, AND, OR, XOR}) ? 1 : 0);
        grow = op inside {LIT, DUP, OVER};
        if (m_stk.size() < need || (grow && m_stk.size() >= DEPTH)) begin
            m_err = 1'b1;
            return;
        end
        case (op)
            LIT:  begin m_stk.push_back(m_tos); m_tos = lit; end
            DUP:  m_stk.push_back(m_tos);
            OVER: begin n = m_stk[$]; m_stk.push_back(m_tos); m_tos = n; end
            DROP: m_tos = m_stk.pop_back();
            ADD:  m_tos = m_stk.pop_back() + m_tos;
            SUB:  m_tos = m_stk.pop_back() - m_tos;
            AND:  m_tos = m_stk.pop_back() & m_tos;
            OR:   m_tos = m_stk.pop_back() | m_tos;
            XOR:  m_tos = m_stk.pop_back() ^ m_tos;
            INV:  m_tos = ~m_tos;
            SWAP: begin
                n = m_stk.pop_back();
                m_stk.push_back(m_tos);
                m_tos = n;
                busy = 1;
            end
            ROT: begin
                b = m_stk.pop_back();
                a = m_stk.pop_back();
                m_stk.push_back(b);
                m_stk.push_back(m_tos);
                m_tos = a;
                busy = 3;
            end
            default: ;
        endcase
    endtask

    task automatic compare();
        int eff;
        check("op_ready", 64'(op_ready), 64'(en && busy == 0));
        check("tos", 64'(tos), 64'(m_tos));
        check("err", 64'(err), 64'(m_err));
        check("strobe_excl", 64'(ss_push & ss_pop), 64'(0));
        if (!en) check("strobe_gated", 64'({ss_push, ss_pop}), 64'(0));
        if (busy == 0) check("depth", 64'(depth), 64'(m_stk.size()));
        if (busy == 0 && en && rst) begin
            eff = sp + int'(ss_push) - int'(ss_pop);
            check("stack_size", 64'(eff), 64'(m_stk.size()));
            if (m_stk.size() >= 1) check("nos", 64'(ss_s0), 64'(m_stk[$]));
            if (m_stk.size() >= 2) check("third", 64'(ss_s1), 64'(m_stk[$-1]));
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            if (rst) model_step();
            else model_reset();
            @(negedge clk);
            if (!rst) model_reset();
            compare();
        end
    end

    task automatic issue(input op_t o, input logic [31:0] l);
        int guard = 0;
        while (!op_ready && guard < 20) begin
            @(posedge clk);
            #2;
            guard++;
        end
        if (!op_ready) begin
            n_checks++;
            n_errors++;
            $display("FAIL issue_timeout: op_ready got 0, required 1 (t=%0t)", $time);
        end
        op = o;
        lit = l;
        op_valid = 1'b1;
        @(posedge clk);
        #2;
        op_valid = 1'b0;
        op = NOP;
        lit = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge clk);
        #2;
        check("rst_tos", 64'(tos), 64'(0));
        check("rst_depth", 64'(depth), 64'(0));
        check("rst_err", 64'(err), 64'(0));
        check("rst_push", 64'(ss_push), 64'(0));
        check("rst_pop", 64'(ss_pop), 64'(0));
        check("rst_vi", 64'(ss_vi), 64'(0));
        check("rst_ready", 64'(op_ready), 64'(1));
        rst = 1'b1;

        // Fifteen literals, one push per cycle carrying the previous TOS.
        for (int i = 0; i < 15; i++) begin
            issue(LIT, 32'(1000 + i));
            check("lit_push", 64'(ss_push), 64'(1));
            check("lit_vi", 64'(ss_vi), 64'((i == 0) ? 0 : 999 + i));
        end
        check("lit_tos", 64'(tos), 64'(1014));
        check("lit_depth", 64'(depth), 64'(15));
        check("lit_err", 64'(err), 64'(0));
        issue(LIT, 32'd2000);
        check("full_depth", 64'(depth), 64'(16));
        issue(LIT, 32'd3000);
        check("ovf_err", 64'(err), 64'(1));
        check("ovf_tos", 64'(tos), 64'(2000));
        check("ovf_depth", 64'(depth), 64'(16));
        check("ovf_nopush", 64'(ss_push), 64'(0));
        do_reset();

        // ROT on ( 1 2 3 )
        issue(LIT, 32'd1);
        issue(LIT, 32'd2);
        issue(LIT, 32'd3);
        issue(ROT, '0);
        for (int k = 0; k < 3; k++) begin
            check("rot_busy", 64'(op_ready), 64'(0));
            idle(1);
        end
        check("rot_ready", 64'(op_ready), 64'(1));
        check("rot_tos", 64'(tos), 64'(1));
        check("rot_s0", 64'(ss_s0), 64'(3));
        check("rot_s1", 64'(ss_s1), 64'(2));
        check("rot_depth", 64'(depth), 64'(3));
        do_reset();

        // SWAP then SUB on ( 5 9 )
        issue(LIT, 32'd5);
        issue(LIT, 32'd9);
        issue(SWAP, '0);
        idle(1);
        check("swap_tos", 64'(tos), 64'(5));
        check("swap_nos", 64'(ss_s0), 64'(9));
        issue(SUB, '0);
        check("sub_tos", 64'(tos), 64'(4));
        check("sub_depth", 64'(depth), 64'(1));

        // Wrap-around ADD, then INV
        issue(LIT, 32'd1);
        issue(LIT, 32'hFFFF_FFFF);
        issue(ADD, '0);
        check("add_tos", 64'(tos), 64'(0));
        check("add_depth", 64'(depth), 64'(2));
        issue(INV, '0);
        check("inv_tos", 64'(tos), 64'hFFFF_FFFF);
        check("inv_depth", 64'(depth), 64'(2));

        // Mixed primitives and en stalls, checked by the model
        issue(LIT, 32'h00FF_00FF);
        issue(OVER, '0);
        issue(AND, '0);
        issue(LIT, 32'h0F0F_0F0F);
        issue(OR, '0);
        issue(XOR, '0);
        issue(DUP, '0);
        issue(DROP, '0);
        issue(SWAP, '0);
        en = 1'b0;
        idle(3);
        en = 1'b1;
        idle(2);
        issue(LIT, 32'd77);
        en = 1'b0;
        idle(2);
        en = 1'b1;
        idle(1);
        issue(ROT, '0);
        idle(4);
        do_reset();

        // Underflow and short-stack ROT
        issue(DROP, '0);
        check("udf_err", 64'(err), 64'(1));
        check("udf_tos", 64'(tos), 64'(0));
        check("udf_depth", 64'(depth), 64'(0));
        check("udf_nopop", 64'(ss_pop), 64'(0));
        issue(LIT, 32'd7);
        issue(ROT, '0);
        check("rotv_ready", 64'(op_ready), 64'(1));
        check("rotv_tos", 64'(tos), 64'(7));
        check("rotv_depth", 64'(depth), 64'(1));
        do_reset();
        check("err_clear", 64'(err), 64'(0));

        // Reset during the second cycle of ROT
        issue(LIT, 32'd1);
        issue(LIT, 32'd2);
        issue(LIT, 32'd3);
        issue(ROT, '0);
        idle(1);
        rst = 1'b0;
        #1;
        check("mid_tos", 64'(tos), 64'(0));
        check("mid_depth", 64'(depth), 64'(0));
        check("mid_err", 64'(err), 64'(0));
        check("mid_push", 64'(ss_push), 64'(0));
        check("mid_pop", 64'(ss_pop), 64'(0));
        check("mid_vi", 64'(ss_vi), 64'(0));
        check("mid_ready", 64'(op_ready), 64'(1));
        @(posedge clk);
        #2;
        check("mid_nopush", 64'(ss_push), 64'(0));
        check("mid_nopop", 64'(ss_pop), 64'(0));
        rst = 1'b1;
        idle(3);
        check("post_push", 64'(ss_push), 64'(0));
        check("post_depth", 64'(depth), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
